// File: rtl/counter_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// counter_ctrl_pkg
// Board-level constants shared by the iCEstick tops, plus the prescale helper
// used by counter_ctrl to derive its tick divider.
// ---------------------------------------------------------------------------
package counter_ctrl_pkg;

  // iCEstick on-board oscillator
  localparam int BOARD_CLK_HZ = 12_000_000;

  // Number of clock cycles between count enables. The caller guarantees the
  // result is >= 2.
  function automatic int calc_prescale(input int clk_hz, input int tick_hz);
    return clk_hz / tick_hz;
  endfunction

endpackage

// File: rtl/counter_ctrl_if.sv
// ---------------------------------------------------------------------------
// counter_ctrl_if
// Bundles the raw buttons and the single-cycle counter controls.
//   btn_run_i   : raw run/pause button, active-high, asynchronous
//   btn_clear_i : raw clear button, active-high, asynchronous
//   count_o     : one-cycle count enable to the counter
//   clear_o     : one-cycle clear to the counter
//   running_o   : high while in RUN (status LED)
// master = board/button side, slave = counter_ctrl.
// ---------------------------------------------------------------------------
interface counter_ctrl_if;

  logic btn_run_i;
  logic btn_clear_i;
  logic count_o;
  logic clear_o;
  logic running_o;

  modport master (
    output btn_run_i, btn_clear_i,
    input  count_o, clear_o, running_o
  );

  modport slave (
    input  btn_run_i, btn_clear_i,
    output count_o, clear_o, running_o
  );

endinterface

// File: rtl/counter_ctrl_button_debouncer.sv
// ---------------------------------------------------------------------------
// button_debouncer
// Synchronizes one raw button, debounces it, and emits a registered one-cycle
// pulse one cycle after the debounced level rises.
//   clock_i   : system clock
//   reset_n_i : asynchronous active-low reset
//   btn_i     : raw button, asynchronous to clock_i
//   level_o   : debounced level
//   rise_o    : one-cycle pulse on debounced 0->1
// ---------------------------------------------------------------------------
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 120000,
  parameter int SYNC_STAGES     = 2
) (
  input  logic clock_i,
  input  logic reset_n_i,
  input  logic btn_i,
  output logic level_o,
  output logic rise_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CW-1:0]          r_cnt;
  logic                   r_level;
  logic                   r_level_d;
  logic                   r_rise;
  logic                   w_sync;

  assign w_sync = r_sync[SYNC_STAGES-1];

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_sync    <= '0;
      r_cnt     <= '0;
      r_level   <= 1'b0;
      r_level_d <= 1'b0;
      r_rise    <= 1'b0;
    end else begin
      r_sync    <= {r_sync[SYNC_STAGES-2:0], btn_i};
      r_level_d <= r_level;
      r_rise    <= r_level & ~r_level_d;
      if (w_sync == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        // This edge is the DEBOUNCE_CYCLES-th consecutive differing cycle.
        r_level <= w_sync;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign level_o = r_level;
  assign rise_o  = r_rise;

endmodule

// File: rtl/counter_ctrl.sv
// ---------------------------------------------------------------------------
// counter_ctrl
// Turns the run and clear push-buttons into clean single-cycle controls for
// the 8-bit counter: run/pause toggle, prescaled count enable, clear pulse.
//   clock_i   : system clock
//   reset_n_i : asynchronous active-low reset
//   bus_if    : counter_ctrl_if.slave (buttons in, count/clear/running out)
//
// state   | meaning
// IDLE    | paused, prescaler holds, no count enables
// RUN     | prescaler cycles 0..PRESCALE-1, count_o after each wrap
// ---------------------------------------------------------------------------
module counter_ctrl
  import counter_ctrl_pkg::*;
#(
  parameter int CLK_HZ          = BOARD_CLK_HZ,
  parameter int TICK_HZ         = 10,
  parameter int DEBOUNCE_CYCLES = 120000,
  parameter int SYNC_STAGES     = 2
) (
  input  logic          clock_i,
  input  logic          reset_n_i,
  counter_ctrl_if.slave bus_if
);

  localparam int PRESCALE = calc_prescale(CLK_HZ, TICK_HZ);
  localparam int PW       = $clog2(PRESCALE);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic          w_run_rise;
  logic          w_clr_rise;
  logic          w_run_level;
  logic          w_clr_level;
  logic [1:0]    w_unused_levels;
  logic          w_presc_wrap;

  logic [0:0]    r_state;
  logic [PW-1:0] r_presc;
  logic          r_count;
  logic          r_clear;

  button_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .SYNC_STAGES    (SYNC_STAGES)
  ) u_run_btn (
    .clock_i  (clock_i),
    .reset_n_i(reset_n_i),
    .btn_i    (bus_if.btn_run_i),
    .level_o  (w_run_level),
    .rise_o   (w_run_rise)
  );

  button_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .SYNC_STAGES    (SYNC_STAGES)
  ) u_clr_btn (
    .clock_i  (clock_i),
    .reset_n_i(reset_n_i),
    .btn_i    (bus_if.btn_clear_i),
    .level_o  (w_clr_level),
    .rise_o   (w_clr_rise)
  );

  // Only the edge pulses drive this block; the levels are left for debug.
  assign w_unused_levels = {w_run_level, w_clr_level};

  assign w_presc_wrap = (r_presc == PW'(PRESCALE - 1));

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state <= ST_IDLE;
      r_presc <= '0;
      r_count <= 1'b0;
      r_clear <= 1'b0;
    end else begin
      r_clear <= w_clr_rise;
      // A clear, or leaving RUN on this edge, suppresses the count enable.
      r_count <= (r_state == ST_RUN) && w_presc_wrap && !w_clr_rise && !w_run_rise;

      if (w_run_rise) begin
        r_state <= (r_state == ST_IDLE) ? ST_RUN : ST_IDLE;
      end

      if (w_clr_rise || (w_run_rise && (r_state == ST_IDLE))) begin
        r_presc <= '0;
      end else if (r_state == ST_RUN) begin
        r_presc <= w_presc_wrap ? '0 : r_presc + PW'(1);
      end
    end
  end

  assign bus_if.count_o   = r_count;
  assign bus_if.clear_o   = r_clear;
  assign bus_if.running_o = (r_state == ST_RUN);

endmodule

// File: tb/tb_counter_ctrl.sv
// ---------------------------------------------------------------------------
// tb_counter_ctrl
// Directed bench for counter_ctrl with CLK_HZ=100, TICK_HZ=10 (PRESCALE=10),
// DEBOUNCE_CYCLES=4, SYNC_STAGES=2. Inputs change and outputs are sampled on
// the falling clock edge. "Press edge" E0 is the first rising edge that
// samples a newly driven button level; a clean press is seen on running_o or
// clear_o after E7 (2 sync + 4 debounce + 1 pulse register).
// ---------------------------------------------------------------------------
module tb_counter_ctrl;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  int   n_vec   = 0;
  int   n_err   = 0;

  counter_ctrl_if u_if ();

  counter_ctrl #(
    .CLK_HZ         (100),
    .TICK_HZ        (10),
    .DEBOUNCE_CYCLES(4),
    .SYNC_STAGES    (2)
  ) dut (
    .clock_i  (clock),
    .reset_n_i(reset_n),
    .bus_if   (u_if)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic run;
    logic clr;
    int   ticks;
    logic exp_running;
    logic exp_count;
    logic exp_clear;
  } vec_t;

  vec_t vecs[$];

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic check(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %b, expected %b", name, $time, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic run_e, input logic cnt_e,
                           input logic clr_e);
    check({tag, " running_o"}, u_if.running_o, run_e);
    check({tag, " count_o"},   u_if.count_o,   cnt_e);
    check({tag, " clear_o"},   u_if.clear_o,   clr_e);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    u_if.btn_run_i   = 1'b0;
    u_if.btn_clear_i = 1'b0;

    // Glitch rejection: 5 x (3 cycles high, 3 low), then settle low.
    for (int i = 0; i < 5; i++) begin
      vecs.push_back('{1'b1, 1'b0, 3, 1'b0, 1'b0, 1'b0});
      vecs.push_back('{1'b0, 1'b0, 3, 1'b0, 1'b0, 1'b0});
    end
    vecs.push_back('{1'b0, 1'b0, 6, 1'b0, 1'b0, 1'b0});
    // Clean run press held ~20 cycles: RUN after E7, count_o after E17/E27/E37.
    vecs.push_back('{1'b1, 1'b0, 7, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 1, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 9, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 1, 1'b1, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 1, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 8, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1, 1'b1, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 8, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1, 1'b1, 1'b1, 1'b0});

    // Power-on reset state
    tick(3);
    check_all("por", 1'b0, 1'b0, 1'b0);
    reset_n = 1'b1;

    foreach (vecs[i]) begin
      u_if.btn_run_i   = vecs[i].run;
      u_if.btn_clear_i = vecs[i].clr;
      tick(vecs[i].ticks);
      check_all($sformatf("vec%0d", i), vecs[i].exp_running, vecs[i].exp_count,
                vecs[i].exp_clear);
    end

    // Clear mid-run: prescaler is 0 here; wait 9, press clear so clear_o lands
    // on the edge that follows prescaler = 6.
    tick(9);
    u_if.btn_clear_i = 1'b1;
    tick(7);
    check_all("clr_pre", 1'b1, 1'b0, 1'b0);
    tick(1);
    check_all("clr_pulse", 1'b1, 1'b0, 1'b1);
    u_if.btn_clear_i = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      tick(1);
      check_all($sformatf("clr_gap%0d", k), 1'b1, 1'b0, 1'b0);
    end
    tick(1);
    check_all("clr_next_count", 1'b1, 1'b1, 1'b0);

    // Pause with a second clean press, then stay idle with no count enables.
    u_if.btn_run_i = 1'b1;
    tick(7);
    check("pause_pre running_o", u_if.running_o, 1'b1);
    tick(1);
    check("pause running_o", u_if.running_o, 1'b0);
    for (int k = 1; k <= 30; k++) begin
      if (k == 12) u_if.btn_run_i = 1'b0;
      tick(1);
      check($sformatf("idle%0d count_o", k), u_if.count_o, 1'b0);
      check($sformatf("idle%0d running_o", k), u_if.running_o, 1'b0);
    end

    // Resume: first count_o exactly 10 cycles after running_o rises.
    u_if.btn_run_i = 1'b1;
    tick(7);
    check("resume_pre running_o", u_if.running_o, 1'b0);
    tick(1);
    check("resume running_o", u_if.running_o, 1'b1);
    for (int k = 1; k <= 10; k++) begin
      tick(1);
      check($sformatf("resume%0d count_o", k), u_if.count_o, (k == 10));
    end
    u_if.btn_run_i = 1'b0;
    tick(10);

    // Back to IDLE for the simultaneous-press case.
    u_if.btn_run_i = 1'b1;
    tick(8);
    check("repause running_o", u_if.running_o, 1'b0);
    u_if.btn_run_i = 1'b0;
    tick(12);
    check("repause_hold running_o", u_if.running_o, 1'b0);

    // Both buttons on the same edge from IDLE.
    u_if.btn_run_i   = 1'b1;
    u_if.btn_clear_i = 1'b1;
    tick(7);
    check_all("both_pre", 1'b0, 1'b0, 1'b0);
    tick(1);
    check_all("both", 1'b1, 1'b0, 1'b1);
    for (int k = 1; k <= 9; k++) begin
      tick(1);
      check_all($sformatf("both_gap%0d", k), 1'b1, 1'b0, 1'b0);
    end
    tick(1);
    check_all("both_count", 1'b1, 1'b1, 1'b0);

    // Asynchronous reset mid-cycle while count_o is high and buttons held.
    reset_n = 1'b0;
    #1;
    check_all("rst_async", 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 5; k++) begin
      tick(1);
      check_all($sformatf("rst_hold%0d", k), 1'b0, 1'b0, 1'b0);
    end

    // Release with both buttons still held: accepted as fresh presses.
    reset_n = 1'b1;
    tick(7);
    check_all("rst_rel_pre", 1'b0, 1'b0, 1'b0);
    tick(1);
    check_all("rst_rel", 1'b1, 1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
